seek_sequencer: RTL and testbench
=================================

Name: seek_sequencer

Overview:
- Initiator side of the 2310 relative-seek interface: drives Access Go, Access Rev and 10/20 toward a real or emulated drive.
- Converts an absolute target cylinder, or a recalibrate request, into a series of 1- or 2-cylinder steps.
- Each step is paced by the drive's Access Ready handshake. The block tracks the believed arm position.
- Used by the exerciser/controller path; pairs with the drive-side seek logic on the same bus.

Parameters:
- GO_WIDTH_US, 20, Access Go low pulse width in microseconds.
- SETUP_US, 5, direction/10-20 setup time before Go falls, in microseconds.
- DROP_TIMEOUT_US, 10000, maximum wait for Access Ready to fall after Go.
- RISE_TIMEOUT_US, 50000, maximum wait for Access Ready to rise after it fell.
- MAX_CYL, 202, highest legal cylinder.
- RECAL_MAX_STEPS, 110, reverse 2-cylinder steps allowed before recalibrate fails.

Ports:
- clock  in  1  master clock, 40 MHz
- reset  in  1  synchronous active-high reset
- clkenbl_1usec  in  1  one-clock enable every microsecond
- start  in  1  one-clock pulse: seek to target_cyl
- recal  in  1  one-clock pulse: step reverse until Home, then set position to 0
- target_cyl  in  8  requested cylinder, sampled on start
- BUS_ACCESS_RDY_H  in  1  drive Access Ready, asynchronous
- BUS_HOME_L  in  1  drive Home, low at cylinder 0, asynchronous
- BUS_ACC_GO_L  out  1  Access Go strobe, active low
- BUS_ACC_REV_L  out  1  high = forward, low = reverse
- BUS_10_20_L  out  1  high = 2-cylinder step, low = 1-cylinder step
- current_cyl  out  8  believed arm position
- busy  out  1  operation in progress
- done  out  1  one-clock pulse on successful completion
- error  out  1  sticky; set on timeout, illegal target or recal failure; cleared by the next accepted start or recal

Behaviour:
- Reset values:
  - BUS_ACC_GO_L=1, BUS_ACC_REV_L=1, BUS_10_20_L=0
  - current_cyl=0, busy=0, done=0, error=0
  - state=IDLE, timer=0, step count=0
- Both bus inputs pass through 2-flop synchronizers. Edge detection uses the synchronized value and its delayed copy.
- IDLE:
  - recal has priority over start in the same cycle.
  - start with target_cyl>MAX_CYL: error=1, done pulses, stay IDLE.
  - start with target_cyl==current_cyl: done pulses the next clock, no bus activity, error cleared.
  - Otherwise latch the target, clear error, set busy, go to PLAN.
- start or recal while busy is ignored.
- PLAN:
  - Seek, with diff = |target - current_cyl|:
    - REV_L = (target > current)
    - 10_20_L = (diff >= 2)
    - diff==0 goes to FINISH.
  - Recal:
    - REV_L=0, 10_20_L=1.
    - If synced Home is already low, set current_cyl=0 and go to FINISH.
  - Load timer=SETUP_US, go to SETUP.
- SETUP: decrement on clkenbl_1usec. At 0: GO_L=0, timer=GO_WIDTH_US, go to GO.
- GO: at timer 0: GO_L=1, timer=DROP_TIMEOUT_US, go to WAIT_DROP.
- WAIT_DROP:
  - Falling edge of synced Ready: timer=RISE_TIMEOUT_US, go to WAIT_RISE.
  - Timer 0: error=1, go to FINISH.
- WAIT_RISE:
  - Rising edge of Ready goes to UPDATE.
  - Timer 0: error=1, go to FINISH.
- UPDATE:
  - current_cyl += or -= 1 or 2 per the issued direction and size.
  - Saturate at 0 and MAX_CYL.
  - Synced Home low forces current_cyl=0.
  - Recal: increment step count. If Home is low go to FINISH. Else if count==RECAL_MAX_STEPS set error=1 and go to FINISH. Else go to PLAN.
  - Seek: go to PLAN.
- FINISH: busy=0, done pulses for one clock, go to IDLE.
- Bus output stability: REV_L and 10_20_L change only in PLAN. They are held from SETUP through UPDATE.
- Timers are 16 bits and count only on clkenbl_1usec. The timeout counter also needs a range of at least 50000.
- Reset mid-operation returns everything to reset values and releases GO_L within one clock.

Decomposition:
- Shared package seek_pkg:
  - state encoding constants
  - MAX_CYL
  - bus polarity constants (FWD=1, STEP2=1)
- One sub-module, bus_sync2: 2-flop synchronizer with delayed copy for edge detection; instantiated twice.

Test Plan:
- Reset, then start target_cyl=5 with a responsive drive model (Ready falls 5 ms after Go, rises 10 ms later) -> three steps:
  - step 1: 10_20_L=1, REV_L=1
  - step 2: 10_20_L=1, REV_L=1
  - step 3: 10_20_L=0, REV_L=1
  - current_cyl ends 5, done pulses once, error=0.
- From cylinder 5, start target_cyl=2 -> step 2 reverse then step 1 reverse; current_cyl=2.
- Recal from current_cyl=7, with the model's Home going low after 4 reverse 2-steps -> current_cyl=0, done pulses, exactly 4 Go pulses, each 20 us wide.
- start target_cyl=203 -> no Go pulse, error=1, done pulses.
- Drive model never drops Ready -> error=1 at 10000 us after the Go pulse ends, busy=0, GO_L=1.
- Assert reset during WAIT_RISE -> next clock all outputs at reset values; a start is accepted afterwards.

Source files
------------

// File: rtl/seek_pkg.sv
// Shared types and constants for the 2310 relative-seek initiator.
// Bus polarities are named so the datapath reads in drive terms.
package seek_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_SETUP,
    S_GO,
    S_WAIT_DROP,
    S_WAIT_RISE,
    S_UPDATE,
    S_FINISH
  } state_t;

  localparam int unsigned CYL_MAX = 202;

  localparam logic FWD   = 1'b1;
  localparam logic STEP2 = 1'b1;

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchronizer for an asynchronous drive line, plus a
// one-clock delayed copy of the synchronized value for edge detection.
module bus_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_dly
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign q     = sync_q;
  assign q_dly = dly_q;

endmodule

// File: rtl/seek_sequencer.sv
// Initiator side of the 2310 relative-seek bus: breaks an absolute
// seek or a recalibrate into Access Ready paced 1/2-cylinder steps.
module seek_sequencer
  import seek_pkg::*;
#(
  parameter int unsigned GO_WIDTH_US     = 20,
  parameter int unsigned SETUP_US        = 5,
  parameter int unsigned DROP_TIMEOUT_US = 10000,
  parameter int unsigned RISE_TIMEOUT_US = 50000,
  parameter int unsigned MAX_CYL         = CYL_MAX,
  parameter int unsigned RECAL_MAX_STEPS = 110
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clkenbl_1usec,
  input  logic       start,
  input  logic       recal,
  input  logic [7:0] target_cyl,
  input  logic       BUS_ACCESS_RDY_H,
  input  logic       BUS_HOME_L,
  output logic       BUS_ACC_GO_L,
  output logic       BUS_ACC_REV_L,
  output logic       BUS_10_20_L,
  output logic [7:0] current_cyl,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [15:0] T_GO    = 16'(GO_WIDTH_US);
  localparam logic [15:0] T_SETUP = 16'(SETUP_US);
  localparam logic [15:0] T_DROP  = 16'(DROP_TIMEOUT_US);
  localparam logic [15:0] T_RISE  = 16'(RISE_TIMEOUT_US);
  localparam logic [7:0]  CYL_TOP = 8'(MAX_CYL);
  localparam logic [7:0]  RCL_TOP = 8'(RECAL_MAX_STEPS);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cur_q, cur_d;
  logic [7:0]  tgt_q, tgt_d;
  logic        rmode_q, rmode_d;
  logic        go_q, go_d;
  logic        rev_q, rev_d;
  logic        s2_q, s2_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic rdy, rdy_dly, home, home_dly;

  bus_sync2 #(.RST_VAL(1'b0)) u_rdy (
    .clock (clock),
    .reset (reset),
    .d     (BUS_ACCESS_RDY_H),
    .q     (rdy),
    .q_dly (rdy_dly)
  );

  bus_sync2 #(.RST_VAL(1'b1)) u_home (
    .clock (clock),
    .reset (reset),
    .d     (BUS_HOME_L),
    .q     (home),
    .q_dly (home_dly)
  );

  logic        rdy_fall, rdy_rise, home_low;
  logic [15:0] timer_dec;
  logic [7:0]  diff, amt, nxt_cyl;
  logic [8:0]  fwd_sum;

  // Home must read low on two consecutive samples to count as home.
  assign home_low  = ~(home | home_dly);
  assign rdy_fall  = rdy_dly & ~rdy;
  assign rdy_rise  = ~rdy_dly & rdy;
  assign timer_dec = clkenbl_1usec ? timer_q - 16'd1 : timer_q;
  assign diff      = (tgt_q > cur_q) ? tgt_q - cur_q : cur_q - tgt_q;
  assign amt       = (s2_q == STEP2) ? 8'd2 : 8'd1;
  assign fwd_sum   = {1'b0, cur_q} + {1'b0, amt};

  always_comb begin
    nxt_cyl = cur_q;
    if (rev_q == FWD) begin
      if (fwd_sum > {1'b0, CYL_TOP}) nxt_cyl = CYL_TOP;
      else                           nxt_cyl = fwd_sum[7:0];
    end else begin
      if (cur_q < amt) nxt_cyl = 8'd0;
      else             nxt_cyl = cur_q - amt;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    rmode_d = rmode_q;
    go_d    = go_q;
    rev_d   = rev_q;
    s2_d    = s2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (recal) begin
          rmode_d = 1'b1;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_PLAN;
        end else if (start) begin
          if (target_cyl > CYL_TOP) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (target_cyl == cur_q) begin
            err_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            tgt_d   = target_cyl;
            rmode_d = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_PLAN;
          end
        end
      end
      S_PLAN: begin
        if (rmode_q) begin
          if (home_low) begin
            cur_d   = 8'd0;
            state_d = S_FINISH;
          end else begin
            rev_d   = ~FWD;
            s2_d    = STEP2;
            timer_d = T_SETUP;
            state_d = S_SETUP;
          end
        end else if (diff == 8'd0) begin
          state_d = S_FINISH;
        end else begin
          rev_d   = (tgt_q > cur_q) ? FWD : ~FWD;
          s2_d    = (diff >= 8'd2) ? STEP2 : ~STEP2;
          timer_d = T_SETUP;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (timer_q == 16'd0) begin
          go_d    = 1'b0;
          timer_d = T_GO;
          state_d = S_GO;
        end else begin
          timer_d = timer_dec;
        end
      end
      S_GO: begin
        if (timer_q == 16'd0) begin
          go_d    = 1'b1;
          timer_d = T_DROP;
          state_d = S_WAIT_DROP;
        end else begin
          timer_d = timer_dec;
        end
      end
      S_WAIT_DROP: begin
        if (rdy_fall) begin
          timer_d = T_RISE;
          state_d = S_WAIT_RISE;
        end else if (timer_q == 16'd0) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_dec;
        end
      end
      S_WAIT_RISE: begin
        if (rdy_rise) begin
          state_d = S_UPDATE;
        end else if (timer_q == 16'd0) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_dec;
        end
      end
      S_UPDATE: begin
        cur_d   = home_low ? 8'd0 : nxt_cyl;
        state_d = S_PLAN;
        if (rmode_q) begin
          cnt_d = cnt_q + 8'd1;
          if (home_low) begin
            state_d = S_FINISH;
          end else if (cnt_q + 8'd1 == RCL_TOP) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= 16'd0;
      cnt_q   <= 8'd0;
      cur_q   <= 8'd0;
      tgt_q   <= 8'd0;
      rmode_q <= 1'b0;
      go_q    <= 1'b1;
      rev_q   <= 1'b1;
      s2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      rmode_q <= rmode_d;
      go_q    <= go_d;
      rev_q   <= rev_d;
      s2_q    <= s2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign BUS_ACC_GO_L  = go_q;
  assign BUS_ACC_REV_L = rev_q;
  assign BUS_10_20_L   = s2_q;
  assign current_cyl   = cur_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;

endmodule

// File: tb/tb_seek_sequencer.sv
// Directed bench for seek_sequencer with a scripted 2310 drive model.
// The microsecond enable runs every second clock to keep runs short.
`timescale 1ns/1ps
module tb_seek_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clkenbl_1usec = 1'b0;
  logic       start = 1'b0;
  logic       recal = 1'b0;
  logic [7:0] target_cyl = 8'd0;
  logic       rdy = 1'b1;
  logic       home = 1'b0;
  logic       go_l, rev_l, s2_l;
  logic [7:0] current_cyl;
  logic       busy, done, error;

  seek_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .clkenbl_1usec    (clkenbl_1usec),
    .start            (start),
    .recal            (recal),
    .target_cyl       (target_cyl),
    .BUS_ACCESS_RDY_H (rdy),
    .BUS_HOME_L       (home),
    .BUS_ACC_GO_L     (go_l),
    .BUS_ACC_REV_L    (rev_l),
    .BUS_10_20_L      (s2_l),
    .current_cyl      (current_cyl),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #12.5 clock = ~clock;
  always @(negedge clock) clkenbl_1usec = ~clkenbl_1usec;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_bad = 0;
  int   go_cnt = 0;
  logic log_rev [64];
  logic log_s2  [64];
  int   go_w    [64];
  int   go_fall_cyc = 0;
  int   go_rise_cyc = 0;
  int   mpos = 0;
  int   m_amt;
  bit   drop_en = 1'b1;
  int   err_cyc;
  int   dn_cnt;
  int   g0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive model: Ready falls 50 clocks after Go falls, rises 100 later.
  always begin
    @(negedge go_l);
    if (go_cnt < 64) begin
      log_rev[go_cnt] = rev_l;
      log_s2[go_cnt]  = s2_l;
    end
    go_cnt++;
    if (drop_en) begin
      repeat (50) @(negedge clock);
      rdy = 1'b0;
      repeat (100) @(negedge clock);
      m_amt = s2_l ? 2 : 1;
      if (rev_l) mpos = (mpos + m_amt > 202) ? 202 : mpos + m_amt;
      else       mpos = (mpos < m_amt) ? 0 : mpos - m_amt;
      home = (mpos == 0) ? 1'b0 : 1'b1;
      rdy  = 1'b1;
    end
  end

  always @(negedge go_l) go_fall_cyc = cyc;
  always @(posedge go_l) begin
    go_rise_cyc = cyc;
    if (go_cnt > 0 && go_cnt <= 64) go_w[go_cnt-1] = cyc - go_fall_cyc;
  end

  task automatic run_op(input logic rc, input logic [7:0] tgt,
                        input int limit);
    bit seen;
    g0      = go_cnt;
    err_cyc = -1;
    seen    = 1'b0;
    @(negedge clock);
    target_cyl = tgt;
    if (rc) recal = 1'b1;
    else    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    recal = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (error && err_cyc < 0) err_cyc = cyc;
      if (done) seen = 1'b1;
      else @(negedge clock);
    end
    check("op_done_seen", 32'(seen), 1);
    dn_cnt = seen ? 1 : 0;
    repeat (4) begin
      @(negedge clock);
      if (done) dn_cnt++;
    end
  endtask

  initial begin
    bit found;
    int d;
    repeat (5) @(negedge clock);
    check("rst_go",   32'(go_l), 1);
    check("rst_rev",  32'(rev_l), 1);
    check("rst_1020", 32'(s2_l), 0);
    check("rst_cyl",  32'(current_cyl), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err",  32'(error), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    run_op(1'b0, 8'd5, 2000);
    check("s5_pulses", 32'(go_cnt - g0), 3);
    check("s5_1020", {29'd0, log_s2[g0], log_s2[g0+1], log_s2[g0+2]}, 3'b110);
    check("s5_rev", {29'd0, log_rev[g0], log_rev[g0+1], log_rev[g0+2]}, 3'b111);
    check("s5_cyl",  32'(current_cyl), 5);
    check("s5_done", 32'(dn_cnt), 1);
    check("s5_err",  32'(error), 0);
    check("s5_busy", 32'(busy), 0);

    run_op(1'b0, 8'd2, 2000);
    check("s2_pulses", 32'(go_cnt - g0), 2);
    check("s2_1020", {30'd0, log_s2[g0], log_s2[g0+1]}, 2'b10);
    check("s2_rev", {30'd0, log_rev[g0], log_rev[g0+1]}, 2'b00);
    check("s2_cyl", 32'(current_cyl), 2);

    run_op(1'b0, 8'd7, 2000);
    check("s7_cyl", 32'(current_cyl), 7);

    run_op(1'b1, 8'd0, 3000);
    check("rc_pulses", 32'(go_cnt - g0), 4);
    for (int i = 0; i < 4; i++) begin
      check("rc_rev", 32'(log_rev[g0+i]), 0);
      check("rc_1020", 32'(log_s2[g0+i]), 1);
      check("rc_gow", 32'(go_w[g0+i] >= 39 && go_w[g0+i] <= 42), 1);
    end
    check("rc_cyl",  32'(current_cyl), 0);
    check("rc_done", 32'(dn_cnt), 1);
    check("rc_err",  32'(error), 0);

    run_op(1'b0, 8'd203, 50);
    check("bad_pulses", 32'(go_cnt - g0), 0);
    check("bad_err",  32'(error), 1);
    check("bad_done", 32'(dn_cnt), 1);
    check("bad_busy", 32'(busy), 0);

    run_op(1'b0, 8'd0, 50);
    check("same_pulses", 32'(go_cnt - g0), 0);
    check("same_err",  32'(error), 0);
    check("same_done", 32'(dn_cnt), 1);

    drop_en = 1'b0;
    run_op(1'b0, 8'd3, 25000);
    d = err_cyc - go_rise_cyc;
    check("to_pulses", 32'(go_cnt - g0), 1);
    check("to_err",  32'(error), 1);
    check("to_time", 32'(err_cyc >= 0 && d >= 19990 && d <= 20010), 1);
    check("to_busy", 32'(busy), 0);
    check("to_go",   32'(go_l), 1);
    check("to_cyl",  32'(current_cyl), 0);
    drop_en = 1'b1;

    run_op(1'b0, 8'd3, 2000);
    check("s3_cyl", 32'(current_cyl), 3);
    check("s3_err", 32'(error), 0);

    @(negedge clock);
    target_cyl = 8'd9;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (!rdy) found = 1'b1;
      else @(negedge clock);
    end
    check("mid_rdy_fell", 32'(found), 1);
    repeat (5) @(negedge clock);
    check("mid_busy", 32'(busy), 1);
    check("mid_1020", 32'(s2_l), 1);
    reset = 1'b1;
    @(negedge clock);
    check("mr_go",   32'(go_l), 1);
    check("mr_rev",  32'(rev_l), 1);
    check("mr_1020", 32'(s2_l), 0);
    check("mr_cyl",  32'(current_cyl), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_err",  32'(error), 0);
    reset = 1'b0;
    repeat (250) @(negedge clock);
    mpos = 0;
    home = 1'b0;
    repeat (5) @(negedge clock);

    run_op(1'b0, 8'd1, 2000);
    check("ar_pulses", 32'(go_cnt - g0), 1);
    check("ar_1020", 32'(log_s2[g0]), 0);
    check("ar_cyl",  32'(current_cyl), 1);
    check("ar_err",  32'(error), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
